mgf_enc_arbiter: RTL and testbench

- Shares one MacGuffin encryption pipeline (32 rounds, 64-bit blocks, AXI-Stream-style valid/ready on both sides) between NUM_REQ independent requesters.
- Issues one block per cycle to the engine using round-robin arbitration.
- Records the requester ID of every issued block in an in-order tag FIFO. The pipeline preserves order, so each result is routed back to the requester that issued it.
- Sits between the requester-facing stream ports and the encryption engine's s_axis/m_axis.

---
 rtl/mgf_pkg.sv | 42 ++++
 rtl/mgf_tag_fifo.sv | 71 +++++++
 rtl/mgf_enc_arbiter.sv | 158 +++++++++++++++
 tb/tb_mgf_enc_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgf_pkg.sv
// ----------------------------------------------------------------------------
// mgf_pkg
//   Shared definitions for the MacGuffin engine arbiter slice.
//   - MGF_BLOCK_SIZE / MGF_ROUND_NUM : engine block width and round count
//   - MAX_REQ / MAX_REQ_W            : upper bound on requesters and the index
//                                      width that rr_pick works in
//   - block_t                        : one cipher block
//   - rr_pick(valid, ptr, num_req)   : round-robin grant index
// ----------------------------------------------------------------------------
package mgf_pkg;

   localparam int MGF_BLOCK_SIZE = 64;
   localparam int MGF_ROUND_NUM  = 32;

   localparam int MAX_REQ   = 8;
   localparam int MAX_REQ_W = 3;

   typedef logic [MGF_BLOCK_SIZE-1:0] block_t;

   // Returns the first index with valid set, scanning ptr, ptr+1, ... and
   // wrapping at num_req. The loop runs from the farthest offset down to the
   // nearest, so the nearest valid requester is the last (winning) write.
   // With nothing valid the result is ptr; callers qualify it with |valid.
   function automatic logic [MAX_REQ_W-1:0] rr_pick(
      input logic [MAX_REQ-1:0]   valid,
      input logic [MAX_REQ_W-1:0] ptr,
      input int                   num_req
   );
      logic [MAX_REQ_W-1:0] pick;
      int                   idx;
      pick = ptr;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < num_req) begin
            idx = int'(ptr) + k;
            if (idx >= num_req) idx = idx - num_req;
            if (valid[MAX_REQ_W'(idx)]) pick = MAX_REQ_W'(idx);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mgf_tag_fifo.sv
// ----------------------------------------------------------------------------
// mgf_tag_fifo
//   In-order FIFO of requester tags, one entry per block inside the engine.
//   A push while full or a pop while empty is ignored, so simultaneous push
//   and pop only both take effect when neither boundary blocks them.
//
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push/i_tag write one tag
//   i_pop        retire the head tag
//   o_full       count == DEPTH
//   o_empty      count == 0
//   o_count      occupancy, 0..DEPTH
//   o_head       tag at the read pointer (meaningful when !o_empty)
// ----------------------------------------------------------------------------
module mgf_tag_fifo
   import mgf_pkg::*;
#(
   parameter int TAG_W = 1,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [TAG_W-1:0]         i_tag,
   input  logic                     i_pop,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [TAG_W-1:0]         o_head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [TAG_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_tag;
   end

endmodule

// File: rtl/mgf_enc_arbiter.sv
// ----------------------------------------------------------------------------
// mgf_enc_arbiter
//   Shares one in-order MacGuffin encryption pipeline between NUM_REQ
//   requesters. Blocks are issued round-robin, one per cycle; the requester
//   index of each issued block goes into a tag FIFO and is used to steer the
//   matching result back. A stalled result consumer stalls the whole engine
//   output (head-of-line blocking is accepted).
//
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_tdata/req_tvalid/req_tready     requester plaintext streams
//   eng_in_tdata/tvalid/tready          to engine s_axis
//   eng_out_tdata/tvalid/tready         from engine m_axis
//   res_tdata                           ciphertext, shared by all requesters
//   res_tvalid/res_tready               one-hot result valid, per-requester ready
//   in_flight                           blocks inside the engine (tag count)
//   err_orphan                          sticky: engine result with no tag
//
//   Build option MGF_ARB_STATS_EN adds done_cnt, a free-running 32-bit count
//   of completed results per requester.
// ----------------------------------------------------------------------------
module mgf_enc_arbiter
   import mgf_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int BLOCK_SIZE = MGF_BLOCK_SIZE,
   parameter int TAG_DEPTH  = 32
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0]  req_tdata,
   input  logic [NUM_REQ-1:0]                  req_tvalid,
   output logic [NUM_REQ-1:0]                  req_tready,
   output logic [BLOCK_SIZE-1:0]               eng_in_tdata,
   output logic                                eng_in_tvalid,
   input  logic                                eng_in_tready,
   input  logic [BLOCK_SIZE-1:0]               eng_out_tdata,
   input  logic                                eng_out_tvalid,
   output logic                                eng_out_tready,
   output logic [BLOCK_SIZE-1:0]               res_tdata,
   output logic [NUM_REQ-1:0]                  res_tvalid,
   input  logic [NUM_REQ-1:0]                  res_tready,
   output logic [$clog2(TAG_DEPTH):0]          in_flight,
   output logic                                err_orphan
`ifdef MGF_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][31:0]            done_cnt
`endif
);

   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

   logic [TAG_W-1:0]   r_rr_ptr;
   logic               r_err_orphan;

   logic [MAX_REQ-1:0] w_valid_ext;
   logic [TAG_W-1:0]   w_grant;
   logic               w_any_valid;
   logic               w_full;
   logic               w_empty;
   logic [TAG_W-1:0]   w_head;
   logic [CNT_W-1:0]   w_count;
   logic               w_push;
   logic               w_pop;

   // ---------------------------------------------------------------- issue
   always_comb begin
      w_valid_ext                = '0;
      w_valid_ext[NUM_REQ-1:0]   = req_tvalid;
   end

   assign w_grant     = TAG_W'(rr_pick(w_valid_ext, MAX_REQ_W'(r_rr_ptr), NUM_REQ));
   assign w_any_valid = |req_tvalid;

   // Outputs are forced low while rst_n is held, not only after the first
   // clock edge, so nothing handshakes with a half-reset engine.
   assign eng_in_tvalid = rst_n & w_any_valid & ~w_full;
   assign eng_in_tdata  = req_tdata[w_grant];

   // Ready only reaches the granted requester and only when an issue can
   // happen this cycle, so an idle arbiter shows no ready at all.
   always_comb begin
      req_tready = '0;
      if (rst_n && w_any_valid && eng_in_tready && !w_full)
         req_tready[w_grant] = 1'b1;
   end

   assign w_push = eng_in_tvalid & eng_in_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_push) begin
         r_rr_ptr <= (w_grant == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
      end
   end

   // ---------------------------------------------------------------- tags
   mgf_tag_fifo #(
      .TAG_W (TAG_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_tag   (w_grant),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign in_flight = w_count;

   // ---------------------------------------------------------------- return
   assign res_tdata = eng_out_tdata;

   always_comb begin
      res_tvalid = '0;
      if (rst_n && eng_out_tvalid && !w_empty)
         res_tvalid[w_head] = 1'b1;
   end

   // With no tag outstanding any result is an orphan; accept it so the
   // engine does not wedge, and flag it.
   assign eng_out_tready = rst_n & (w_empty ? eng_out_tvalid : res_tready[w_head]);
   assign w_pop          = eng_out_tvalid & eng_out_tready & ~w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_orphan <= 1'b0;
      end else if (eng_out_tvalid && w_empty) begin
         r_err_orphan <= 1'b1;
      end
   end

   assign err_orphan = r_err_orphan;

`ifdef MGF_ARB_STATS_EN
   // ---------------------------------------------------------------- stats
   logic [NUM_REQ-1:0][31:0] r_done_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (res_tvalid[i] && res_tready[i])
               r_done_cnt[i] <= r_done_cnt[i] + 32'd1;
         end
      end
   end

   assign done_cnt = r_done_cnt;
`endif

endmodule

// File: tb/tb_mgf_enc_arbiter.sv
`timescale 1ns/1ps
module tb_mgf_enc_arbiter;

   localparam int NR      = 2;
   localparam int BS      = 64;
   localparam int TD      = 32;
   localparam int CW      = 6;
   localparam int ENG_LAT = 4;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NR-1:0][BS-1:0] req_tdata;
   logic [NR-1:0]         req_tvalid;
   logic [NR-1:0]         req_tready;
   logic [BS-1:0]         eng_in_tdata;
   logic                  eng_in_tvalid;
   logic                  eng_in_tready;
   logic [BS-1:0]         eng_out_tdata;
   logic                  eng_out_tvalid;
   logic                  eng_out_tready;
   logic [BS-1:0]         res_tdata;
   logic [NR-1:0]         res_tvalid;
   logic [NR-1:0]         res_tready;
   logic [CW-1:0]         in_flight;
   logic                  err_orphan;
`ifdef MGF_ARB_STATS_EN
   logic [NR-1:0][31:0]   done_cnt;
`endif

   mgf_enc_arbiter #(.NUM_REQ(NR), .BLOCK_SIZE(BS), .TAG_DEPTH(TD)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_tdata      (req_tdata),
      .req_tvalid     (req_tvalid),
      .req_tready     (req_tready),
      .eng_in_tdata   (eng_in_tdata),
      .eng_in_tvalid  (eng_in_tvalid),
      .eng_in_tready  (eng_in_tready),
      .eng_out_tdata  (eng_out_tdata),
      .eng_out_tvalid (eng_out_tvalid),
      .eng_out_tready (eng_out_tready),
      .res_tdata      (res_tdata),
      .res_tvalid     (res_tvalid),
      .res_tready     (res_tready),
      .in_flight      (in_flight),
      .err_orphan     (err_orphan)
`ifdef MGF_ARB_STATS_EN
      ,
      .done_cnt       (done_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [7:0] id; logic [63:0] data; } exp_t;
   typedef struct packed { logic [63:0] data; logic [31:0] rdy; } eng_t;

   exp_t        exp_issue_q[$];
   exp_t        exp_res_q[$];
   logic [63:0] q0[$];
   logic [63:0] q1[$];
   eng_t        eng_q[$];

   int unsigned cyc = 0;
   logic [NR-1:0] f_req = '0;
   logic          f_eng_in = 1'b0;
   logic [63:0]   f_eng_in_data = '0;
   logic          f_eng_out = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // Stand-in for the cipher: a fixed, easily hand-evaluated permutation.
   function automatic logic [63:0] eng_f(input logic [63:0] d);
      return {d[31:0], d[63:32]} ^ 64'hA5A5_5A5A_C3C3_3C3C;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Queue a block on requester id; the caller issues in the hand-derived
   // round-robin order so the expectation queues are already in engine order.
   task automatic issue(input int id, input logic [63:0] d);
      exp_t e;
      e.id   = 8'(id);
      e.data = d;
      exp_issue_q.push_back(e);
      e.data = eng_f(d);
      exp_res_q.push_back(e);
      if (id == 0) q0.push_back(d);
      else         q1.push_back(d);
   endtask

   // ------------------------------------------------------------ monitor
   always @(negedge clk) begin
      exp_t e;
      f_req         = req_tvalid & req_tready;
      f_eng_in      = eng_in_tvalid & eng_in_tready;
      f_eng_in_data = eng_in_tdata;
      f_eng_out     = eng_out_tvalid & eng_out_tready & (eng_q.size() > 0);
      if (eng_in_tvalid && eng_in_tready) begin
         if (exp_issue_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL issue_extra: got block %0h, expected none", eng_in_tdata);
         end else begin
            e = exp_issue_q.pop_front();
            chk("issue_data", eng_in_tdata, e.data);
            chk("issue_port", 64'(req_tready), 64'(2'b01 << e.id));
         end
      end
      if (|(res_tvalid & res_tready)) begin
         if (exp_res_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL res_extra: got result %0h on %b, expected none", res_tdata, res_tvalid);
         end else begin
            e = exp_res_q.pop_front();
            chk("res_data", res_tdata, e.data);
            chk("res_port", 64'(res_tvalid), 64'(2'b01 << e.id));
         end
      end
      if (eng_out_tvalid && in_flight == '0)
         chk("orphan_no_res_tvalid", 64'(res_tvalid), 64'd0);
   end

   // ------------------------------------------------- drivers / engine model
   always @(posedge clk) begin
      cyc++;
      #1;
      if (f_req[0] && q0.size() > 0) q0.delete(0);
      if (f_req[1] && q1.size() > 0) q1.delete(0);
      if (f_eng_in) eng_q.push_back({f_eng_in_data, 32'(cyc + ENG_LAT)});
      if (f_eng_out && eng_q.size() > 0) eng_q.delete(0);
      f_req = '0; f_eng_in = 1'b0; f_eng_out = 1'b0;
      req_tvalid[0] = (q0.size() > 0);
      req_tdata[0]  = (q0.size() > 0) ? q0[0] : '0;
      req_tvalid[1] = (q1.size() > 0);
      req_tdata[1]  = (q1.size() > 0) ? q1[0] : '0;
      eng_out_tvalid = (eng_q.size() > 0) && (eng_q[0].rdy <= cyc);
      eng_out_tdata  = eng_out_tvalid ? eng_f(eng_q[0].data) : '0;
   end

   // Engine is reset with the arbiter, so every bench-side queue is dropped.
   task automatic flush_bench();
      q0.delete(); q1.delete(); eng_q.delete();
      exp_issue_q.delete(); exp_res_q.delete();
      f_req = '0; f_eng_in = 1'b0; f_eng_out = 1'b0;
      req_tvalid = '0; eng_out_tvalid = 1'b0;
   endtask

   // Called at posedge+2; returns at posedge+2.
   task automatic do_reset();
      rst_n = 1'b0;
      flush_bench();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic wait_issue(input string name, input int budget);
      int t = 0;
      do begin @(posedge clk); #2; t++; end
      while (exp_issue_q.size() != 0 && t < budget);
      chk(name, 64'(exp_issue_q.size()), 64'd0);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int t = 0;
      do begin @(posedge clk); #2; t++; end
      while ((exp_issue_q.size() != 0 || exp_res_q.size() != 0) && t < budget);
      chk(name, 64'(exp_issue_q.size() + exp_res_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d issues %0d results outstanding",
               exp_issue_q.size(), exp_res_q.size());
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      req_tdata = '0; eng_out_tdata = '0; eng_in_tready = 1'b1;
      res_tready = 2'b11;
      req_tvalid = 2'b11; eng_out_tvalid = 1'b1;
      #3;
      chk("rst_eng_in_tvalid", 64'(eng_in_tvalid), 64'd0);
      chk("rst_req_tready",    64'(req_tready),    64'd0);
      chk("rst_eng_out_tready",64'(eng_out_tready),64'd0);
      chk("rst_res_tvalid",    64'(res_tvalid),    64'd0);
      chk("rst_in_flight",     64'(in_flight),     64'd0);
      chk("rst_err_orphan",    64'(err_orphan),    64'd0);
      do_reset();
      chk("post_rst_err_orphan", 64'(err_orphan), 64'd0);

      // Single requester, hand-evaluated stand-in ciphertext.
      begin
         exp_t e;
         e.id = 8'd0; e.data = 64'h0123_4567_89AB_CDEF;
         exp_issue_q.push_back(e);
         e.data = 64'h2C0E_97B5_C2E0_795B;
         exp_res_q.push_back(e);
         q0.push_back(64'h0123_4567_89AB_CDEF);
      end
      wait_issue("single_issue", 20);
      chk("single_in_flight_1", 64'(in_flight), 64'd1);
      chk("single_no_res_yet",  64'(res_tvalid), 64'd0);
      wait_drain("single_drain", 40);
      chk("single_in_flight_0", 64'(in_flight), 64'd0);

      // Both requesters continuously valid: 0,1,0,1,... one per cycle.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         issue(0, 64'hA000_0000_0000_0000 | 64'(k));
         issue(1, 64'hB000_0000_0000_0000 | 64'(k));
      end
      repeat (9) @(posedge clk);
      #2;
      chk("alt_issue_8cyc", 64'(exp_issue_q.size()), 64'd0);
      wait_drain("alt_drain", 60);
`ifdef MGF_ARB_STATS_EN
      chk("alt_done_cnt0", 64'(done_cnt[0]), 64'd4);
      chk("alt_done_cnt1", 64'(done_cnt[1]), 64'd4);
`endif

      // Steady stream: push and pop every cycle at occupancy 5, 40 blocks
      // so both pointers wrap past depth 32.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         issue(0, 64'hC000_0000_0000_0000 | 64'(k * 3));
         issue(1, 64'hD000_0000_0000_0000 | 64'(k * 7));
      end
      repeat (15) @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         #2 chk("steady_in_flight_5", 64'(in_flight), 64'd5);
         @(posedge clk);
      end
      #2;
      wait_drain("wrap_drain", 120);
      chk("wrap_in_flight_0", 64'(in_flight), 64'd0);
      chk("wrap_err_orphan",  64'(err_orphan), 64'd0);

      // Head-of-line backpressure until the tag FIFO is full.
      do_reset();
      res_tready = 2'b01;
      issue(1, 64'hE000_0000_0000_00FF);
      repeat (3) @(posedge clk);
      #2;
      for (int k = 0; k < 40; k++) issue(0, 64'hF000_0000_0000_0000 | 64'(k));
      repeat (45) @(posedge clk);
      #2;
      chk("bp_full_in_flight",   64'(in_flight),      64'd32);
      chk("bp_eng_in_tvalid",    64'(eng_in_tvalid),  64'd0);
      chk("bp_eng_out_tready",   64'(eng_out_tready), 64'd0);
      chk("bp_res_tvalid_head1", 64'(res_tvalid),     64'd2);
      chk("bp_pending_issues",   64'(exp_issue_q.size()), 64'd9);
      res_tready = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #2 chk("bp_release_in_flight", 64'(in_flight), 64'd31);
      end
      chk("bp_release_eng_in_tvalid", 64'(eng_in_tvalid), 64'd1);
      wait_drain("bp_drain", 120);
      chk("bp_in_flight_0", 64'(in_flight), 64'd0);

      // Orphan result with no tag outstanding.
      do_reset();
      chk("orph_err_before", 64'(err_orphan), 64'd0);
      eng_out_tvalid = 1'b1;
      eng_out_tdata  = 64'h0000_0000_DEAD_BEEF;
      #1;
      chk("orph_res_tvalid",     64'(res_tvalid),     64'd0);
      chk("orph_eng_out_tready", 64'(eng_out_tready), 64'd1);
      @(posedge clk);
      #2 chk("orph_err_set", 64'(err_orphan), 64'd1);
      repeat (5) @(posedge clk);
      #2 chk("orph_err_sticky", 64'(err_orphan), 64'd1);
      rst_n = 1'b0;
      #1 chk("orph_err_async_clr", 64'(err_orphan), 64'd0);
      #1;
      do_reset();

      // Async reset with 10 blocks in flight; last grant 0 leaves rr_ptr=1.
      res_tready = 2'b00;
      for (int k = 0; k < 4; k++) begin
         issue(0, 64'h1000_0000_0000_0000 | 64'(k));
         issue(1, 64'h2000_0000_0000_0000 | 64'(k));
      end
      issue(0, 64'h1000_0000_0000_0004);
      issue(0, 64'h1000_0000_0000_0005);
      repeat (20) @(posedge clk);
      #2;
      chk("ar_in_flight_10",  64'(in_flight),  64'd10);
      chk("ar_res_tvalid_on", 64'(res_tvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("ar_in_flight_clr",     64'(in_flight),     64'd0);
      chk("ar_res_tvalid_clr",    64'(res_tvalid),    64'd0);
      chk("ar_eng_in_tvalid_clr", 64'(eng_in_tvalid), 64'd0);
`ifdef MGF_ARB_STATS_EN
      chk("ar_done_cnt_clr", 64'(done_cnt), 64'd0);
`endif
      #1;
      do_reset();
      res_tready = 2'b11;
      issue(0, 64'h3000_0000_0000_0001);
      issue(1, 64'h3000_0000_0000_0002);
      wait_drain("ar_rr_ptr_zero_drain", 40);
      chk("ar_final_err_orphan", 64'(err_orphan), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
